// File: rtl/jtopl_pkg.sv
// jtopl_pkg
// Shared constants for the YM3014-class serial DAC output path.
//   DAC_MANT_W / DAC_EXP_W : floating-point word field widths
//   SLOT_EXP_LO            : first bit slot carrying the exponent
//   SLOT_PAD_LO            : first padding/latch slot of a frame
//   DAC_RST_WORD           : encoding of a zero sample (m=0, e=1)
package jtopl_pkg;
    localparam int DAC_MANT_W  = 10;
    localparam int DAC_EXP_W   = 3;
    localparam int DAC_WORD_W  = DAC_MANT_W + DAC_EXP_W;

    // Word is sent LSB first: mantissa in slots 0..9, exponent in 10..12.
    localparam int SLOT_EXP_LO = DAC_MANT_W;
    localparam int SLOT_PAD_LO = DAC_WORD_W;

    localparam logic [DAC_WORD_W-1:0] DAC_RST_WORD = {3'd1, 10'd0};

    function automatic logic [DAC_WORD_W-1:0] dac_pack(
        input logic [DAC_EXP_W-1:0]  e,
        input logic [DAC_MANT_W-1:0] m
    );
        logic [DAC_WORD_W-1:0] w;
        w = '0;
        w[DAC_MANT_W-1:0]              = m;
        w[SLOT_EXP_LO +: DAC_EXP_W]    = e;
        return w;
    endfunction
endpackage

// File: rtl/jtopl_dac_fp.sv
// jtopl_dac_fp
// Combinational signed 16-bit to DAC floating-point converter.
// The exponent is the smallest shift+1 (1..7) that brings the sample into
// the 10-bit signed range; the mantissa is the arithmetically shifted
// sample, so dropped low bits truncate toward -inf.
//   i_snd  : signed 16-bit sample
//   o_exp  : exponent, 1..7
//   o_mant : 10-bit two's complement mantissa
module jtopl_dac_fp
    import jtopl_pkg::*;
(
    input  logic [15:0]           i_snd,
    output logic [DAC_EXP_W-1:0]  o_exp,
    output logic [DAC_MANT_W-1:0] o_mant
);
    logic signed [15:0] w_shr;

    always_comb begin
        w_shr  = '0;
        o_exp  = 3'd7;
        o_mant = '0;
        // Walk from the largest shift down so the last hit is the smallest e.
        // e=7 always fits (32767>>6 = 511), so some iteration always hits.
        for (int e = 7; e >= 1; e--) begin
            w_shr = $signed(i_snd) >>> (e - 1);
            if (w_shr[15:9] == {7{w_shr[9]}}) begin
                o_exp  = 3'(e);
                o_mant = w_shr[9:0];
            end
        end
    end
endmodule

// File: rtl/jtopl_dac_ser.sv
// jtopl_dac_ser
// Serialises the accumulator sample to a YM3014-class DAC.
// Each enabled clock is half a bit slot; a frame is FRAME_SLOTS slots
// (legal 14..32): 13 data slots followed by padding slots with sh high.
//   i_clk    : system clock
//   i_rst    : synchronous reset, active high
//   i_cen    : clock enable, one sy phase per enabled cycle
//   i_snd    : signed sample, captured on the frame-load cycle only
//   o_sample : one-clk pulse on the capture cycle
//   o_so     : serial data, LSB first
//   o_sy     : bit clock (low first half of slot, high second half)
//   o_sh     : latch strobe, high during padding slots
module jtopl_dac_ser
    import jtopl_pkg::*;
#(
    parameter int FRAME_SLOTS = 16
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_cen,
    input  logic [15:0] i_snd,
    output logic        o_sample,
    output logic        o_so,
    output logic        o_sy,
    output logic        o_sh
);
    localparam int PH_N = 2 * FRAME_SLOTS;
    localparam int PH_W = $clog2(PH_N);
    localparam int SL_W = PH_W - 1;
    localparam logic [PH_W-1:0] PH_LAST  = PH_W'(PH_N - 1);
    localparam logic [SL_W-1:0] PAD_SLOT = SL_W'(SLOT_PAD_LO);

    logic [PH_W-1:0]       r_ph;
    logic [DAC_WORD_W-1:0] r_sr;
    logic                  r_so;
    logic                  r_sh;

    logic [DAC_EXP_W-1:0]  w_exp;
    logic [DAC_MANT_W-1:0] w_mant;
    logic [DAC_WORD_W-1:0] w_word;
    logic                  w_load;
    logic [PH_W-1:0]       w_ph_nxt;
    logic [SL_W-1:0]       w_slot_nxt;

    jtopl_dac_fp u_fp (
        .i_snd  (i_snd),
        .o_exp  (w_exp),
        .o_mant (w_mant)
    );

    assign w_word     = dac_pack(w_exp, w_mant);
    assign w_load     = i_cen && (r_ph == PH_LAST);
    assign w_ph_nxt   = w_load ? '0 : r_ph + PH_W'(1);
    assign w_slot_nxt = w_ph_nxt[PH_W-1:1];

    // r_sr[0] always mirrors the bit currently on so during data slots:
    // entering a new slot presents r_sr[1] and shifts by one.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ph <= '0;
            r_sr <= DAC_RST_WORD;
            r_so <= DAC_RST_WORD[0];
            r_sh <= 1'b0;
        end else if (i_cen) begin
            r_ph <= w_ph_nxt;
            if (w_load) begin
                r_sr <= w_word;
                r_so <= w_word[0];
                r_sh <= 1'b0;
            end else if (r_ph[0]) begin
                if (w_slot_nxt < PAD_SLOT) begin
                    r_so <= r_sr[1];
                    r_sr <= r_sr >> 1;
                end else begin
                    r_so <= 1'b0;
                end
                r_sh <= (w_slot_nxt >= PAD_SLOT);
            end
        end
    end

    assign o_sample = w_load && !i_rst;
    assign o_so     = r_so;
    assign o_sy     = r_ph[0];
    assign o_sh     = r_sh;
endmodule
